// File: rtl/pe_mac_pipe_pkg.sv
// Shared types and limits for the pe_mac_pipe processing element.
package pe_mac_pipe_pkg;

    typedef enum logic [1:0] {
        PE_MUL    = 2'd0,
        PE_MULADD = 2'd1,
        PE_PE     = 2'd2,
        PE_ACC    = 2'd3
    } pe_mode_t;

    localparam int PE_MAX_LAT = 8;

    // Modes that consume the second product m*q.
    function automatic logic pe_uses_mq(input pe_mode_t mode);
        return (mode == PE_PE) || (mode == PE_ACC);
    endfunction

endpackage

// File: rtl/pe_delay_line.sv
// Enable-gated register chain of configurable width and depth; depth 0 is a plain wire.
module pe_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = clk ^ rst_n ^ ce;
        assign o_data   = i_data;
    end else begin : g_chain
        logic [W-1:0] w_tap [DEPTH+1];
        assign w_tap[0] = i_data;

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] r_data;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (ce) begin
                    r_data <= w_tap[gi];
                end
            end
            assign w_tap[gi+1] = r_data;
        end

        assign o_data = w_tap[DEPTH];
    end

endmodule

// File: rtl/pe_mac_pipe.sv
// Multi-mode MAC pipeline (MUL / MULADD / PE / ACC) with tag tracking, clock-enable stall
// and a running accumulator that is read and written only in the final stage.
module pe_mac_pipe
    import pe_mac_pipe_pkg::*;
#(
    parameter int AW       = 26,
    parameter int BW       = 17,
    parameter int PW       = 48,
    parameter int SU_SHIFT = 17,
    parameter int SL_SHIFT = 0,
    parameter int LAT      = 3,
    parameter int TW       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [1:0]        in_mode,
    input  logic              in_first,
    input  logic [AW-1:0]     in_a,
    input  logic [BW-1:0]     in_b,
    input  logic [AW-1:0]     in_m,
    input  logic [BW-1:0]     in_q,
    input  logic [PW-1:0]     in_s,
    input  logic [PW-2*BW-1:0] in_su,
    input  logic [2*BW-1:0]   in_sl,
    input  logic [TW-1:0]     in_tag,
    output logic              out_valid,
    output logic [PW-1:0]     out_s,
    output logic [TW-1:0]     out_tag,
    output logic [PW-1:0]     acc_q
);

    localparam int OP_DEPTH = (LAT >= 2) ? 1 : 0;
    localparam int PR_DEPTH = (LAT >= 2) ? LAT - 2 : 0;
    localparam int CW       = 1 + TW + 2 + 1;
    localparam int OPW      = CW + 2*AW + 2*BW + PW;
    localparam int PRW      = CW + 3*PW;

    if (LAT < 1 || LAT > PE_MAX_LAT) begin : g_lat_check
        $error("pe_mac_pipe: LAT=%0d outside 1..%0d", LAT, PE_MAX_LAT);
    end

    // Operand masking happens before any register so unused inputs never reach the sum.
    pe_mode_t        w_in_mode;
    logic            w_in_uses_mq;
    logic            w_in_first;
    logic [AW-1:0]   w_in_m;
    logic [BW-1:0]   w_in_q;
    logic [PW-1:0]   w_in_addend;

    always_comb begin
        w_in_mode    = pe_mode_t'(in_mode);
        w_in_uses_mq = pe_uses_mq(w_in_mode);
        w_in_first   = (w_in_mode == PE_ACC) && in_first;
        w_in_m       = w_in_uses_mq ? in_m : '0;
        w_in_q       = w_in_uses_mq ? in_q : '0;
        w_in_addend  = '0;
        case (w_in_mode)
            PE_MULADD: w_in_addend = in_s;
            PE_PE:     w_in_addend = (PW'(in_su) << SU_SHIFT) + (PW'(in_sl) << SL_SHIFT);
            PE_ACC:    w_in_addend = w_in_first ? in_s : '0;
            default:   w_in_addend = '0;
        endcase
    end

    logic [OPW-1:0] w_op_d;
    logic [OPW-1:0] w_op_q;

    assign w_op_d = {in_valid, in_tag, w_in_mode, w_in_first,
                     in_a, in_b, w_in_m, w_in_q, w_in_addend};

    pe_delay_line #(.W(OPW), .DEPTH(OP_DEPTH)) u_op_dl (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .i_data (w_op_d),
        .o_data (w_op_q)
    );

    logic            w_s1_valid;
    logic [TW-1:0]   w_s1_tag;
    logic [1:0]      w_s1_mode;
    logic            w_s1_first;
    logic [AW-1:0]   w_s1_a;
    logic [BW-1:0]   w_s1_b;
    logic [AW-1:0]   w_s1_m;
    logic [BW-1:0]   w_s1_q;
    logic [PW-1:0]   w_s1_addend;
    logic [PW-1:0]   w_s1_ab;
    logic [PW-1:0]   w_s1_mq;

    assign {w_s1_valid, w_s1_tag, w_s1_mode, w_s1_first,
            w_s1_a, w_s1_b, w_s1_m, w_s1_q, w_s1_addend} = w_op_q;

    assign w_s1_ab = PW'(w_s1_a) * PW'(w_s1_b);
    assign w_s1_mq = PW'(w_s1_m) * PW'(w_s1_q);

    logic [PRW-1:0] w_pr_d;
    logic [PRW-1:0] w_pr_q;

    assign w_pr_d = {w_s1_valid, w_s1_tag, w_s1_mode, w_s1_first,
                     w_s1_ab, w_s1_mq, w_s1_addend};

    pe_delay_line #(.W(PRW), .DEPTH(PR_DEPTH)) u_pr_dl (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .i_data (w_pr_d),
        .o_data (w_pr_q)
    );

    logic            w_f_valid;
    logic [TW-1:0]   w_f_tag;
    logic [1:0]      w_f_mode;
    logic            w_f_first;
    logic [PW-1:0]   w_f_ab;
    logic [PW-1:0]   w_f_mq;
    logic [PW-1:0]   w_f_addend;
    logic            w_f_is_acc;
    logic [PW-1:0]   w_f_result;

    logic            r_out_valid;
    logic [PW-1:0]   r_out_s;
    logic [TW-1:0]   r_out_tag;
    logic [PW-1:0]   r_acc;

    assign {w_f_valid, w_f_tag, w_f_mode, w_f_first,
            w_f_ab, w_f_mq, w_f_addend} = w_pr_q;

    // The accumulator is sampled here, next to its own register, so back-to-back ACC chains.
    assign w_f_is_acc = (w_f_mode == PE_ACC);
    assign w_f_result = w_f_ab + w_f_mq + w_f_addend
                      + ((w_f_is_acc && !w_f_first) ? r_acc : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_tag   <= '0;
            r_acc       <= '0;
        end else if (ce) begin
            r_out_valid <= w_f_valid;
            if (w_f_valid) begin
                r_out_s   <= w_f_result;
                r_out_tag <= w_f_tag;
                if (w_f_is_acc) begin
                    r_acc <= w_f_result;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_tag   = r_out_tag;
    assign acc_q     = r_acc;

endmodule
